// File: rtl/spi_cmd_responder.sv
// spi_cmd_responder: oversampled SPI slave decoding commands and memory frames into write/read strobes; define SPI_STATUS_EN to return a status byte during the command byte
module spi_cmd_responder #(
  parameter int ADDR_W = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              MOSI,
  input  logic              chip_select_n,
  output logic              MISO,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_byte,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              proc_enable,
  output logic              soft_reset,
  input  logic              done
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR_HI, ADDR_LO, WRITE, READ, IGNORE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q;
  logic sck_d, cs_d, rise_d, rd_pend, rd_frame;
  logic [6:0] rx_sr;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr, rx_byte, status;
  logic [ADDR_W-9:0] hi;
  logic [ADDR_W-1:0] addr;
  logic rise, cs_fall, cs_rise, byte_done, cmd_go, hi_go, lo_go, wr_go, rd_go;
`ifdef SPI_STATUS_EN
  assign status = {done, proc_enable, 6'b0};
`else
  logic unused_done;
  assign unused_done = done;
  assign status = 8'h00;
`endif
  assign rise = sck_q[SYNC_STAGES-1] & ~sck_d;
  assign cs_fall = ~cs_q[SYNC_STAGES-1] & cs_d;
  assign cs_rise = cs_q[SYNC_STAGES-1] & ~cs_d;
  assign rx_byte = {rx_sr, mosi_q[SYNC_STAGES-1]};
  assign byte_done = rise && bit_cnt == 3'd7;
  assign MISO = tx_sr[7];
  // Next-state and per-byte action strobes; a chip-select rise wins only after the byte's action
  always_comb begin
    cmd_go = byte_done && state == CMD;
    hi_go = byte_done && state == ADDR_HI;
    lo_go = byte_done && state == ADDR_LO;
    wr_go = byte_done && state == WRITE;
    rd_go = byte_done && state == READ;
    state_nxt = state;
    case (state)
      IDLE: state_nxt = cs_fall ? CMD : IDLE;
      CMD: state_nxt = !byte_done ? CMD : (rx_byte == 8'h0F || rx_byte[7:6] != 2'b00) ? ADDR_HI : IGNORE;
      ADDR_HI: state_nxt = byte_done ? ADDR_LO : ADDR_HI;
      ADDR_LO: state_nxt = !byte_done ? ADDR_LO : rd_frame ? READ : WRITE;
      default: state_nxt = state;
    endcase
    if (cs_rise) state_nxt = IDLE;
  end
  // Synchronizers, bit/byte assembly, MISO shifter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sck_q <= '0;
      mosi_q <= '0;
      cs_q <= '0;
      sck_d <= 1'b0;
      cs_d <= 1'b0;
      rise_d <= 1'b0;
      rd_pend <= 1'b0;
      rd_frame <= 1'b0;
      rx_sr <= '0;
      bit_cnt <= '0;
      tx_sr <= '0;
      hi <= '0;
      addr <= '0;
      wr_en <= 1'b0;
      wr_sel <= 2'b00;
      wr_addr <= '0;
      wr_byte <= '0;
      rd_en <= 1'b0;
      rd_addr <= '0;
      proc_enable <= 1'b0;
      soft_reset <= 1'b0;
    end else begin
      state <= state_nxt;
      sck_q <= {sck_q[SYNC_STAGES-2:0], spi_clk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      cs_q <= {cs_q[SYNC_STAGES-2:0], chip_select_n};
      sck_d <= sck_q[SYNC_STAGES-1];
      cs_d <= cs_q[SYNC_STAGES-1];
      rise_d <= rise;
      rd_pend <= rd_en;
      bit_cnt <= (state == IDLE || cs_rise) ? 3'd0 : rise ? bit_cnt + 3'd1 : bit_cnt;
      rx_sr <= rise ? rx_byte[6:0] : rx_sr;
      tx_sr <= cs_fall ? status : (rd_pend && state == READ) ? rd_data : rise_d ? {tx_sr[6:0], 1'b0} : tx_sr;
      rd_frame <= cmd_go ? rx_byte == 8'h0F : rd_frame;
      wr_sel <= (cmd_go && rx_byte[7:6] != 2'b00) ? rx_byte[7:6] : wr_sel;
      proc_enable <= (cmd_go && rx_byte == 8'h0C) ? 1'b0 : (cmd_go && rx_byte == 8'h0E) ? 1'b1 : proc_enable;
      soft_reset <= cmd_go && rx_byte == 8'h0D;
      hi <= hi_go ? rx_byte[ADDR_W-9:0] : hi;
      addr <= lo_go ? {hi, rx_byte} : (wr_go || rd_go) ? addr + ADDR_W'(1) : addr;
      wr_en <= wr_go;
      wr_addr <= wr_go ? addr : wr_addr;
      wr_byte <= wr_go ? rx_byte : wr_byte;
      rd_en <= rd_go || (lo_go && rd_frame);
      rd_addr <= lo_go ? {hi, rx_byte} : rd_go ? addr + ADDR_W'(1) : rd_addr;
    end
  end
endmodule

// File: tb/tb_spi_cmd_responder.sv
// tb_spi_cmd_responder: directed SPI host frames against spi_cmd_responder with a small activation memory model
module tb_spi_cmd_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_clk = 1'b0;
  logic MOSI = 1'b0;
  logic chip_select_n = 1'b1;
  logic MISO, wr_en, rd_en, proc_enable, soft_reset;
  logic [1:0] wr_sel;
  logic [12:0] wr_addr, rd_addr;
  logic [7:0] wr_byte;
  logic [7:0] rd_data = 8'h00;
  logic done = 1'b0;
  int checks = 0;
  int errors = 0;
  int wn = 0, rn = 0, sn = 0, both = 0;
  logic [1:0] ws [32];
  logic [12:0] wa [32];
  logic [7:0] wb [32];
  logic [12:0] ra [32];
  logic [7:0] got [5];
  logic [7:0] scratch;
  int b;
  logic [7:0] status_exp;

  spi_cmd_responder dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .MOSI(MOSI), .chip_select_n(chip_select_n),
    .MISO(MISO), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_byte(wr_byte),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .proc_enable(proc_enable),
    .soft_reset(soft_reset), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= (rd_addr == 13'd5) ? 8'h3C : (rd_addr == 13'd6) ? 8'hC3 : 8'h00;

  always @(negedge clk) begin
    if (wr_en && wn < 32) begin ws[wn] = wr_sel; wa[wn] = wr_addr; wb[wn] = wr_byte; end
    if (wr_en) wn++;
    if (rd_en && rn < 32) ra[rn] = rd_addr;
    if (rd_en) rn++;
    if (soft_reset) sn++;
    if (wr_en && rd_en) both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host shifts MOSI MSB first and captures MISO just before each rising spi_clk edge
  task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = tx[i];
      #80;
      rx[i] = MISO;
      spi_clk = 1'b1;
      #80;
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame(input int len, input logic [7:0] b0, b1, b2, b3, b4);
    logic [7:0] tx [5];
    tx = '{b0, b1, b2, b3, b4};
    @(negedge clk);
    chip_select_n = 1'b0;
    #80;
    for (int k = 0; k < len; k++) xfer(tx[k], 8, got[k]);
    #80;
    chip_select_n = 1'b1;
    #200;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso", MISO, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_sel", wr_sel, 2'b00);
    check("rst_wr_addr", wr_addr, 13'd0);
    check("rst_wr_byte", wr_byte, 8'h00);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, 13'd0);
    check("rst_proc_enable", proc_enable, 1'b0);
    check("rst_soft_reset", soft_reset, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    frame(1, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00);
    check("cmd0E_pe", proc_enable, 1'b1);
    frame(1, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00);
    check("cmd0D_pulses", sn, 1);
    check("cmd0D_pe_kept", proc_enable, 1'b1);
    frame(1, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00);
    check("cmd0C_pe", proc_enable, 1'b0);
    check("cmd_no_wr", wn, 0);
    check("cmd_no_rd", rn, 0);

    b = wn;
    frame(5, 8'h80, 8'h00, 8'h10, 8'hAA, 8'h55);
    check("act_wr_count", wn - b, 2);
    check("act_sel0", ws[b], 2'b10);
    check("act_addr0", wa[b], 13'h010);
    check("act_byte0", wb[b], 8'hAA);
    check("act_sel1", ws[b+1], 2'b10);
    check("act_addr1", wa[b+1], 13'h011);
    check("act_byte1", wb[b+1], 8'h55);

    b = wn;
    frame(5, 8'h40, 8'h1F, 8'hFF, 8'h01, 8'h02);
    check("wrap_wr_count", wn - b, 2);
    check("wrap_sel", ws[b], 2'b01);
    check("wrap_addr0", wa[b], 13'h1FFF);
    check("wrap_byte0", wb[b], 8'h01);
    check("wrap_addr1", wa[b+1], 13'h0000);
    check("wrap_byte1", wb[b+1], 8'h02);

    frame(1, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef SPI_STATUS_EN
    status_exp = 8'h40;
`else
    status_exp = 8'h00;
`endif
    b = wn;
    frame(5, 8'h0F, 8'h00, 8'h05, 8'h00, 8'h00);
    check("rd_miso0", got[0], status_exp);
    check("rd_miso1", got[1], 8'h00);
    check("rd_miso2", got[2], 8'h00);
    check("rd_miso3", got[3], 8'h3C);
    check("rd_miso4", got[4], 8'hC3);
    check("rd_count", rn, 3);
    check("rd_addr0", ra[0], 13'd5);
    check("rd_addr1", ra[1], 13'd6);
    check("rd_no_wr", wn - b, 0);

    b = wn;
    @(negedge clk);
    chip_select_n = 1'b0;
    #80;
    xfer(8'hC0, 8, scratch);
    xfer(8'h00, 8, scratch);
    xfer(8'h00, 8, scratch);
    xfer(8'hFF, 4, scratch);
    #80;
    chip_select_n = 1'b1;
    #200;
    check("abort_no_wr", wn - b, 0);
    frame(4, 8'hC0, 8'h00, 8'h00, 8'h77, 8'h00);
    check("abort_wr_count", wn - b, 1);
    check("abort_sel", ws[b], 2'b11);
    check("abort_addr", wa[b], 13'd0);
    check("abort_byte", wb[b], 8'h77);
    check("no_wr_rd_overlap", both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
